// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch and the MEM stage,
// with MEM priority, alternation under contention and a ready-timeout abort.
module mem_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_se,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [1:0]        ram_size,
  output logic              ram_se,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_error
);
  typedef enum logic [1:0] {IDLE, SERVE_MEM, SERVE_IF, DONE} state_t;
  state_t state, next;
  logic last_grant;
  logic served_mem, err, serve, pick_mem, timeout, grant;
  logic [7:0] cnt;
  assign serve      = (state == SERVE_MEM) || (state == SERVE_IF);
  // last_grant = 1 means fetch was granted last, so MEM wins the next tie
  assign pick_mem   = mem_enable & (~if_req | last_grant);
  assign grant      = (state == IDLE) & (mem_enable | if_req);
  assign timeout    = ~ram_ready & (cnt == 8'(MAX_WAIT - 1));
  assign ram_enable = serve;
  assign if_done    = (state == DONE) & ~served_mem;
  assign mem_done   = (state == DONE) & served_mem;
  assign bus_error  = (state == DONE) & err;
  assign stall_if   = if_req & ~if_done;
  assign stall_mem  = mem_enable & ~mem_done;
  always_comb begin
    next = (state == IDLE) ? (grant ? (pick_mem ? SERVE_MEM : SERVE_IF) : IDLE) :
           (state == DONE) ? IDLE :
           (ram_ready | timeout) ? DONE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      served_mem <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
      ram_rw     <= 1'b0;
      ram_size   <= '0;
      ram_se     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      state <= next;
      if (grant) begin
        cnt        <= '0;
        err        <= 1'b0;
        last_grant <= ~pick_mem;
        served_mem <= pick_mem;
        ram_rw     <= pick_mem & mem_rw;
        ram_size   <= pick_mem ? mem_size : 2'b10;
        ram_se     <= pick_mem & mem_se;
        ram_addr   <= pick_mem ? mem_addr : if_addr;
        ram_wdata  <= pick_mem ? mem_wdata : '0;
      end
      if (serve && ram_ready && !ram_rw) begin
        if (served_mem) mem_rdata <= ram_rdata;
        else if_rdata <= ram_rdata;
      end
      if (serve && !ram_ready) begin
        cnt <= cnt + 8'd1;
        err <= timeout;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences for timeout and
// reset during an access.
module tb_mem_port_arbiter;
  logic clk = 0, reset = 0;
  logic if_req = 0, mem_enable = 0, mem_rw = 0, mem_se = 0, ram_ready = 0;
  logic [8:0] if_addr = 0, mem_addr = 0, ram_addr;
  logic [1:0] mem_size = 0, ram_size;
  logic [31:0] mem_wdata = 0, ram_rdata = 0, if_rdata, mem_rdata, ram_wdata;
  logic if_done, mem_done, ram_enable, ram_rw, ram_se, stall_if, stall_mem, bus_error;
  int n_cmp = 0, n_err = 0, n;

  mem_port_arbiter #(.ADDR_W(9), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_se(mem_se), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_size(ram_size),
    .ram_se(ram_se), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ready(ram_ready), .stall_if(stall_if), .stall_mem(stall_mem), .bus_error(bus_error));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, ia, me, rw, sz, se, ma, wd, rr, rd;
    logic [31:0] en, xrw, xsz, xse, xa, xwd, ifd, md, sif, smem, be, mr, xir;
  } vec_t;
  vec_t vt[25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input int i);
    chk($sformatf("v%0d ram_enable", i), 32'(ram_enable), vt[i].en);
    chk($sformatf("v%0d ram_rw", i), 32'(ram_rw), vt[i].xrw);
    chk($sformatf("v%0d ram_size", i), 32'(ram_size), vt[i].xsz);
    chk($sformatf("v%0d ram_se", i), 32'(ram_se), vt[i].xse);
    chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), vt[i].xa);
    chk($sformatf("v%0d ram_wdata", i), ram_wdata, vt[i].xwd);
    chk($sformatf("v%0d if_done", i), 32'(if_done), vt[i].ifd);
    chk($sformatf("v%0d mem_done", i), 32'(mem_done), vt[i].md);
    chk($sformatf("v%0d stall_if", i), 32'(stall_if), vt[i].sif);
    chk($sformatf("v%0d stall_mem", i), 32'(stall_mem), vt[i].smem);
    chk($sformatf("v%0d bus_error", i), 32'(bus_error), vt[i].be);
    chk($sformatf("v%0d mem_rdata", i), mem_rdata, vt[i].mr);
    chk($sformatf("v%0d if_rdata", i), if_rdata, vt[i].xir);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //        ir  ia    me rw sz se ma     wd           rr rd             en rw sz se a      wd    ifd md sif sm be mr            ir
    vt[0]  = '{0,'h044,0,0,2,0,'h020,0,1,'h11112222,  1,0,2,0,'h044,0,    0,0,0,0,0,0,'h0};
    vt[1]  = '{0,'h044,0,0,2,0,'h020,0,0,0,           0,0,2,0,'h044,0,    1,0,0,0,0,0,'h11112222};
    vt[2]  = '{0,'h044,1,0,2,0,'h010,0,0,0,           0,0,2,0,'h044,0,    0,0,0,1,0,0,'h11112222};
    vt[3]  = '{0,'h044,1,0,2,0,'h010,0,1,'hDEADBEEF,  1,0,2,0,'h010,0,    0,0,0,1,0,0,'h11112222};
    vt[4]  = '{0,'h044,0,0,2,0,'h010,0,0,0,           0,0,2,0,'h010,0,    0,1,0,0,0,'hDEADBEEF,'h11112222};
    vt[5]  = '{0,'h044,1,1,0,0,'h0A3,'hAB,0,0,        0,0,2,0,'h010,0,    0,0,0,1,0,'hDEADBEEF,'h11112222};
    vt[6]  = '{0,'h044,1,0,2,1,'h1FF,'hFFFFFFFF,0,0,  1,1,0,0,'h0A3,'hAB, 0,0,0,1,0,'hDEADBEEF,'h11112222};
    vt[7]  = vt[6];
    vt[8]  = vt[6];
    vt[9]  = '{0,'h044,1,0,2,1,'h1FF,'hFFFFFFFF,1,'h55555555, 1,1,0,0,'h0A3,'hAB, 0,0,0,1,0,'hDEADBEEF,'h11112222};
    vt[10] = '{0,'h044,0,0,2,0,'h000,0,0,0,           0,1,0,0,'h0A3,'hAB, 0,1,0,0,0,'hDEADBEEF,'h11112222};
    vt[11] = '{1,'h100,1,0,1,1,'h008,0,0,0,           0,1,0,0,'h0A3,'hAB, 0,0,1,1,0,'hDEADBEEF,'h11112222};
    vt[12] = '{1,'h100,1,0,1,1,'h008,0,1,'hA0000001,  1,0,2,0,'h100,0,    0,0,1,1,0,'hDEADBEEF,'h11112222};
    vt[13] = '{1,'h104,1,0,1,1,'h008,0,0,0,           0,0,2,0,'h100,0,    1,0,0,1,0,'hDEADBEEF,'hA0000001};
    vt[14] = '{1,'h104,1,0,1,1,'h008,0,0,0,           0,0,2,0,'h100,0,    0,0,1,1,0,'hDEADBEEF,'hA0000001};
    vt[15] = '{1,'h104,1,0,1,1,'h008,0,1,'hB0000002,  1,0,1,1,'h008,0,    0,0,1,1,0,'hDEADBEEF,'hA0000001};
    vt[16] = '{1,'h104,1,0,1,1,'h008,0,0,0,           0,0,1,1,'h008,0,    0,1,1,0,0,'hB0000002,'hA0000001};
    vt[17] = '{1,'h104,1,0,1,1,'h008,0,0,0,           0,0,1,1,'h008,0,    0,0,1,1,0,'hB0000002,'hA0000001};
    vt[18] = '{1,'h104,1,0,1,1,'h008,0,1,'hC0000003,  1,0,2,0,'h104,0,    0,0,1,1,0,'hB0000002,'hA0000001};
    vt[19] = '{1,'h104,1,0,1,1,'h008,0,0,0,           0,0,2,0,'h104,0,    1,0,0,1,0,'hB0000002,'hC0000003};
    vt[20] = '{1,'h104,1,0,1,1,'h008,0,0,0,           0,0,2,0,'h104,0,    0,0,1,1,0,'hB0000002,'hC0000003};
    vt[21] = '{1,'h104,1,0,1,1,'h008,0,1,'hD0000004,  1,0,1,1,'h008,0,    0,0,1,1,0,'hB0000002,'hC0000003};
    vt[22] = '{0,'h104,0,0,1,1,'h008,0,0,0,           0,0,1,1,'h008,0,    0,1,0,0,0,'hD0000004,'hC0000003};
    vt[23] = '{0,'h104,0,0,1,1,'h008,0,1,'hEEEEEEEE,  0,0,1,1,'h008,0,    0,0,0,0,0,'hD0000004,'hC0000003};
    vt[24] = '{0,'h104,0,0,1,1,'h008,0,0,0,           0,0,1,1,'h008,0,    0,0,0,0,0,'hD0000004,'hC0000003};

    // reset held with both requesters asking
    if_req = 1; if_addr = 9'h044; mem_enable = 1; mem_addr = 9'h020; mem_size = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ram_enable", 32'(ram_enable), 0);
    chk("rst ram_addr", 32'(ram_addr), 0);
    chk("rst ram_size", 32'(ram_size), 0);
    chk("rst ram_rw", 32'(ram_rw), 0);
    chk("rst ram_wdata", ram_wdata, 0);
    chk("rst dones", {30'd0, if_done, mem_done}, 0);
    chk("rst rdata", if_rdata | mem_rdata, 0);
    reset = 1;

    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if_req = vt[i].ir[0]; if_addr = vt[i].ia[8:0]; mem_enable = vt[i].me[0];
      mem_rw = vt[i].rw[0]; mem_size = vt[i].sz[1:0]; mem_se = vt[i].se[0];
      mem_addr = vt[i].ma[8:0]; mem_wdata = vt[i].wd; ram_ready = vt[i].rr[0];
      ram_rdata = vt[i].rd;
      @(negedge clk);
      chk_vec(i);
    end

    // timeout: RAM never ready
    mem_enable = 1; mem_rw = 0; mem_size = 2'b10; mem_se = 0; mem_addr = 9'h1F0; ram_ready = 0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ram_enable) n++;
      else if (n > 0) break;
    end
    chk("to serve_cycles", n, 15);
    chk("to bus_error", 32'(bus_error), 1);
    chk("to mem_done", 32'(mem_done), 1);
    chk("to if_done", 32'(if_done), 0);
    chk("to mem_rdata", mem_rdata, 32'hD0000004);
    mem_enable = 0;
    @(negedge clk);
    chk("to idle enable", 32'(ram_enable), 0);
    chk("to idle error", 32'(bus_error), 0);

    // reset while serving MEM with fetch pending
    mem_enable = 1; mem_addr = 9'h0C0;
    @(negedge clk);
    chk("rs serve enable", 32'(ram_enable), 1);
    chk("rs serve addr", 32'(ram_addr), 32'h0C0);
    if_req = 1; if_addr = 9'h0C4;
    #2 reset = 0;
    #1;
    chk("rs clr enable", 32'(ram_enable), 0);
    chk("rs clr addr", 32'(ram_addr), 0);
    chk("rs no mem_done", 32'(mem_done), 0);
    chk("rs clr mem_rdata", mem_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rs held no done", {30'd0, if_done, mem_done}, 0);
    reset = 1;
    @(negedge clk);
    chk("rs if grant enable", 32'(ram_enable), 1);
    chk("rs if grant addr", 32'(ram_addr), 32'h0C4);
    chk("rs if grant size", 32'(ram_size), 2);
    ram_ready = 1; ram_rdata = 32'h0BADF00D;
    @(negedge clk);
    chk("rs if_done", 32'(if_done), 1);
    chk("rs if_rdata", if_rdata, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
